// File: rtl/nms_pkg.sv
// Shared types for the non-maximum-suppression stage.
// Direction codes, pixel bundle and FSM state.
package nms_pkg;

  localparam int MAG_W = 12;

  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]       dir;
    logic [MAG_W-1:0] mag;
  } pix_t;

endpackage

// File: rtl/nms_linebuf.sv
// One line of pixels: simple dual-port RAM, 1-cycle read.
// Contents are never reset; the border rule hides stale data.
module nms_linebuf
  import nms_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output pix_t          o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pix_t          i_wdata
);

  pix_t r_mem [DEPTH];
  pix_t r_rdata;

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/nms_stage.sv
// Non-maximum suppression over a 3x3 window of
// gradient magnitudes, streaming in raster order.
module nms_stage
  import nms_pkg::*;
#(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 768
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sof,
  input  logic [MAG_W-1:0] mag_in,
  input  logic [1:0]       dir_in,
  output logic             out_valid,
  output logic [MAG_W-1:0] val_aft_nms
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);
  localparam int SW = $clog2(IMG_W + 3);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FL_MAX  = FW'(IMG_W);
  localparam logic [SW-1:0] SH_FULL = SW'(IMG_W + 2);

  state_t r_state, w_nxt;
  logic [CW-1:0] r_icol, w_col, r_s1_col, r_ocol;
  logic [RW-1:0] r_irow, r_orow;
  logic [FW-1:0] r_fcnt;
  logic [SW-1:0] r_scnt, w_scnt;
  logic w_acc, w_start, w_shift, w_last;
  logic r_s1_v, r_s1_first, r_cv, r_fresh;
  pix_t w_pix, r_s1_pix, w_lb0, w_lb1;
  pix_t r_w [3][3];
  logic [MAG_W-1:0] w_na, w_nb, w_mc, w_res;
  logic w_border;

  assign w_acc   = in_valid & in_ready;
  assign w_start = w_acc & sof;
  assign w_shift = (w_acc & (sof | (r_state == RUN)))
                 | (r_state == FLUSH);
  assign w_last  = w_acc & ~sof & (r_state == RUN)
                 & (r_irow == ROW_MAX) & (r_icol == COL_MAX);
  assign w_col   = w_start ? '0 : r_icol;
  assign w_pix   = (r_state == FLUSH) ? '0 : {dir_in, mag_in};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nxt = RUN;
      RUN:     if (w_last) w_nxt = FLUSH;
      FLUSH:   if (r_fcnt == FL_MAX) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (r_state != FLUSH);
  end

  // input position counters and flush counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icol <= '0;
      r_irow <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_shift) begin
        if (w_start) begin
          r_icol <= CW'(1);
          r_irow <= '0;
        end else if (r_icol == COL_MAX) begin
          r_icol <= '0;
          r_irow <= (r_irow == ROW_MAX) ? '0
                  : r_irow + RW'(1);
        end else begin
          r_icol <= r_icol + CW'(1);
        end
      end
      r_fcnt <= (r_state == FLUSH) ? r_fcnt + FW'(1) : '0;
    end
  end

  // stage 1: hold the shifted pixel while the RAM reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_col   <= '0;
    end else begin
      r_s1_v     <= w_shift;
      r_s1_first <= w_start;
      if (w_shift) begin
        r_s1_pix <= w_pix;
        r_s1_col <= w_col;
      end
    end
  end

  nms_linebuf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .i_re    (w_shift),
    .i_raddr (w_col),
    .o_rdata (w_lb0),
    .i_we    (r_s1_v),
    .i_waddr (r_s1_col),
    .i_wdata (r_s1_pix)
  );

  nms_linebuf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .i_re    (w_shift),
    .i_raddr (w_col),
    .o_rdata (w_lb1),
    .i_we    (r_s1_v),
    .i_waddr (r_s1_col),
    .i_wdata (w_lb0)
  );

  // shifts seen this frame, saturating once centre is valid
  always_comb begin
    w_scnt = r_scnt;
    if (r_s1_first)              w_scnt = SW'(1);
    else if (r_scnt != SH_FULL)  w_scnt = r_scnt + SW'(1);
  end

  // window shift and centre position tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_w[i][j] <= '0;
      r_scnt  <= '0;
      r_cv    <= 1'b0;
      r_orow  <= '0;
      r_ocol  <= '0;
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= r_s1_v;
      if (r_s1_v) begin
        for (int i = 0; i < 3; i++) begin
          r_w[i][0] <= r_w[i][1];
          r_w[i][1] <= r_w[i][2];
        end
        r_w[0][2] <= w_lb1;
        r_w[1][2] <= w_lb0;
        r_w[2][2] <= r_s1_pix;
        r_scnt <= w_scnt;
        r_cv   <= (w_scnt == SH_FULL);
        if (r_s1_first || r_scnt != SH_FULL) begin
          r_orow <= '0;
          r_ocol <= '0;
        end else if (r_ocol == COL_MAX) begin
          r_ocol <= '0;
          r_orow <= (r_orow == ROW_MAX) ? '0
                  : r_orow + RW'(1);
        end else begin
          r_ocol <= r_ocol + CW'(1);
        end
      end
    end
  end

  // neighbour pick and keep/suppress decision
  always_comb begin
    w_mc = r_w[1][1].mag;
    w_na = r_w[1][0].mag;
    w_nb = r_w[1][2].mag;
    case (r_w[1][1].dir)
      DIR_45: begin
        w_na = r_w[0][2].mag;
        w_nb = r_w[2][0].mag;
      end
      DIR_90: begin
        w_na = r_w[0][1].mag;
        w_nb = r_w[2][1].mag;
      end
      DIR_135: begin
        w_na = r_w[0][0].mag;
        w_nb = r_w[2][2].mag;
      end
      default: begin
        w_na = r_w[1][0].mag;
        w_nb = r_w[1][2].mag;
      end
    endcase
    w_border = (r_orow == '0) | (r_orow == ROW_MAX)
             | (r_ocol == '0) | (r_ocol == COL_MAX);
    w_res = '0;
    if (!w_border && w_mc > w_na && w_mc >= w_nb)
      w_res = w_mc;
  end

  // output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      val_aft_nms <= '0;
    end else begin
      out_valid <= r_fresh & r_cv;
      if (r_fresh & r_cv) val_aft_nms <= w_res;
    end
  end

endmodule

// File: tb/tb_nms_stage.sv
// Bench for nms_stage: 8x6 frames, image-coordinate model,
// expected pixels queued at drive time and popped per pulse.
module tb_nms_stage;
  import nms_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sof = 1'b0;
  logic [11:0] mag_in = '0;
  logic [1:0] dir_in = '0;
  logic in_ready, out_valid;
  logic [11:0] val_aft_nms;

  int total = 0;
  int bad = 0;
  int npulse = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;
  int n0;
  bit mark_first = 1'b0;
  logic [11:0] exq[$];
  logic [11:0] fm [H][W];
  logic [1:0] fd [H][W];

  nms_stage #(.IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sof         (sof),
    .mag_in      (mag_in),
    .dir_in      (dir_in),
    .out_valid   (out_valid),
    .val_aft_nms (val_aft_nms)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_px(int r, int c);
    int ar, ac, br, bc;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 12'd0;
    case (fd[r][c])
      2'd0: begin ar = r;   ac = c-1; br = r;   bc = c+1; end
      2'd1: begin ar = r-1; ac = c+1; br = r+1; bc = c-1; end
      2'd2: begin ar = r-1; ac = c;   br = r+1; bc = c;   end
      default: begin ar = r-1; ac = c-1; br = r+1; bc = c+1; end
    endcase
    if (fm[r][c] > fm[ar][ac] && fm[r][c] >= fm[br][bc])
      return fm[r][c];
    return 12'd0;
  endfunction

  // pop and compare each output pulse
  always @(negedge clk) begin
    if (out_valid) begin
      npulse++;
      if (mark_first) begin
        first_cyc = cyc;
        mark_first = 1'b0;
      end
      if (exq.size() == 0) chk("extra_pulse", 1, 0);
      else chk("pixel", {20'd0, val_aft_nms}, {20'd0, exq.pop_front()});
    end
  end

  task automatic idle();
    in_valid = 1'b0;
    sof = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic put(input logic s, input logic [11:0] m,
                     input logic [1:0] d);
    int g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    sof = s;
    mag_in = m;
    dir_in = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit expect_out);
    if (expect_out)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          exq.push_back(ref_px(r, c));
    mark_first = expect_out;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        for (int g = 0; g < 4 && $urandom_range(0, 99) < gap; g++)
          idle();
        put(r == 0 && c == 0, fm[r][c], fd[r][c]);
        if (r*W + c == W + 1) acc_cyc = cyc;
      end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exq.size() != 0 || !in_ready) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_drain"}, exq.size(), 0);
  endtask

  task automatic run(input string tag, input int gap);
    n0 = npulse;
    send_frame(gap, 1'b1);
    drain(tag);
    chk({tag, "_count"}, npulse - n0, W*H);
  endtask

  task automatic fill(input logic [11:0] m, input logic [1:0] d);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fm[r][c] = m;
        fd[r][c] = d;
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fm[r][c] = 12'($urandom_range(0, 15));
        fd[r][c] = 2'($urandom_range(0, 3));
      end
  endtask

  initial begin
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_val", val_aft_nms, 0);
    chk("rst_in_ready", in_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    fill(12'd100, 2'd0);
    run("flat", 0);
    chk("latency", first_cyc - acc_cyc, 2);

    fill(12'd10, 2'd2);
    fm[2][3] = 12'd500;
    run("spike", 0);

    fill(12'd10, 2'd0);
    fm[2][1] = 12'd200;
    fm[2][2] = 12'd200;
    run("ridge", 0);

    fill(12'd4094, 2'd3);
    fm[3][4] = 12'd4095;
    run("maxval", 0);

    fill_rand();
    run("rand_nogap", 0);
    run("rand_gap", 50);

    n0 = npulse;
    for (int i = 0; i < 5; i++) put(1'b0, 12'd999, 2'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("drop_pulses", npulse - n0, 0);
    chk("drop_state", 32'(dut.r_state), 32'(IDLE));

    for (int i = 0; i < 7; i++)
      put(i == 0, 12'($urandom_range(0, 4095)), 2'($urandom));
    fill_rand();
    run("restart", 0);

    fill_rand();
    send_frame(0, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("flush_rst_valid", out_valid, 0);
    chk("flush_rst_ready", in_ready, 1);
    chk("flush_rst_state", 32'(dut.r_state), 32'(IDLE));
    exq.delete();
    n0 = npulse;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_pulses", npulse - n0, 0);

    fill_rand();
    run("recover", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
